// File: rtl/ha_1.sv
// Half adder with a combinational sum/carry path, a valid-qualified output register
// stage and a saturating count of carry-producing operations.
module ha_1 #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             in_valid,
    output logic             s,
    output logic             c,
    output logic             s_q,
    output logic             c_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // The same sum/carry gates drive both the ports and the register stage.
    assign s = a ^ b;
    assign c = a & b;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q       <= 1'b0;
            c_q       <= 1'b0;
            out_valid <= 1'b0;
            carry_cnt <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                s_q <= s;
                c_q <= c;
                // Stop at the all-ones value instead of wrapping.
                if (c && (carry_cnt != CNT_MAX)) begin
                    carry_cnt <= carry_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ha_1.sv
// Self-checking bench for ha_1: directed scenarios plus a randomized run, all
// compared against an arithmetic reference model. Two instances: CNT_W=16 and CNT_W=2.
module tb_ha_1;

    logic        clk = 1'b0;
    logic        rst, a, b, in_valid;
    logic        s, c, s_q, c_q, out_valid;
    logic [15:0] carry_cnt;
    logic        s2, c2, s_q2, c_q2, out_valid2;
    logic [1:0]  carry_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic exp_sq, exp_cq, exp_ov;
    int   n_carry;

    always #5 clk = ~clk;

    ha_1 #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
        .s(s), .c(c), .s_q(s_q), .c_q(c_q), .out_valid(out_valid),
        .carry_cnt(carry_cnt)
    );

    ha_1 #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
        .s(s2), .c(c2), .s_q(s_q2), .c_q(c_q2), .out_valid(out_valid2),
        .carry_cnt(carry_cnt2)
    );

    function automatic int sat(input int n, input int w);
        int lim;
        lim = (1 << w) - 1;
        return (n > lim) ? lim : n;
    endfunction

    // Model of one rising edge, written from the arithmetic meaning of a half adder.
    task automatic model_edge(input logic ia, input logic ib, input logic iv, input logic ir);
        int sum;
        sum = int'(ia) + int'(ib);
        if (ir) begin
            exp_sq = 1'b0; exp_cq = 1'b0; exp_ov = 1'b0; n_carry = 0;
        end else begin
            exp_ov = iv;
            if (iv) begin
                exp_sq  = logic'(sum % 2);
                exp_cq  = logic'(sum / 2);
                n_carry = n_carry + sum / 2;
            end
        end
    endtask

    // Drive inputs after the falling edge, let the rising edge happen, sample 1 unit later.
    task automatic cycle(input logic ia, input logic ib, input logic iv, input logic ir);
        @(negedge clk);
        a = ia; b = ib; in_valid = iv; rst = ir;
        @(posedge clk);
        model_edge(ia, ib, iv, ir);
        #1;
    endtask

    task automatic test_reset;
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if ({s_q, c_q, out_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_regs: got s_q/c_q/ov=%b%b%b expected 000", s_q, c_q, out_valid);
        end
        n_checks++;
        if (carry_cnt !== 16'd0 || carry_cnt2 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d/%0d expected 0/0", carry_cnt, carry_cnt2);
        end
    endtask

    // Sum and carry must follow a,b within one time unit whatever rst/in_valid are doing.
    task automatic test_comb(input logic ir);
        logic [1:0] ab;
        int         exp_sum;
        @(negedge clk);
        rst = ir; in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            a = ab[1]; b = ab[0];
            #1;
            exp_sum = int'(ab[1]) + int'(ab[0]);
            n_checks++;
            if ({c, s} !== 2'(exp_sum) || {c2, s2} !== 2'(exp_sum)) begin
                n_fail++;
                $display("FAIL comb_ab%b_rst%b: got c,s=%b%b expected %0d", ab, ir, c, s, exp_sum);
            end
        end
        @(posedge clk);
        model_edge(a, b, in_valid, rst);
        #1;
    endtask

    task automatic test_registered;
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if ({c_q, s_q, out_valid} !== {exp_cq, exp_sq, exp_ov} || {c_q, s_q, out_valid} !== 3'b101) begin
            n_fail++;
            $display("FAIL reg_load: got c_q/s_q/ov=%b%b%b expected 101", c_q, s_q, out_valid);
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if ({c_q, s_q, out_valid} !== {exp_cq, exp_sq, exp_ov} || {c_q, s_q, out_valid} !== 3'b100) begin
                n_fail++;
                $display("FAIL reg_hold%0d: got c_q/s_q/ov=%b%b%b expected 100", i, c_q, s_q, out_valid);
            end
        end
    endtask

    task automatic test_counter;
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            if (i % 3 == 1) cycle(1'b0, 1'b1, 1'b1, 1'b0);
            else            cycle(1'b1, 1'b1, 1'b1, 1'b0);
            cycle(1'b1, 1'b1, 1'b0, 1'b0);  // idle 11 must not count
        end
        n_checks++;
        if (carry_cnt !== 16'(sat(n_carry, 16)) || carry_cnt !== 16'd5) begin
            n_fail++;
            $display("FAIL counter_5: got %0d expected 5", carry_cnt);
        end
    endtask

    task automatic test_saturation;
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b0);
            n_checks++;
            if (carry_cnt2 !== 2'(sat(n_carry, 2)) || carry_cnt !== 16'(i)) begin
                n_fail++;
                $display("FAIL saturate_%0d: got %0d/%0d expected %0d/%0d",
                         i, carry_cnt2, carry_cnt, sat(n_carry, 2), i);
            end
        end
    endtask

    task automatic test_reset_priority;
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        a = 1'b1; b = 1'b1; in_valid = 1'b1; rst = 1'b1;
        #1;
        n_checks++;
        if (c !== 1'b1 || s !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_comb: got c,s=%b%b expected 10", c, s);
        end
        @(posedge clk);
        model_edge(1'b1, 1'b1, 1'b1, 1'b1);
        #1;
        n_checks++;
        if ({out_valid, c_q, s_q} !== 3'b000 || carry_cnt !== 16'd0 || carry_cnt2 !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_priority: got ov/c_q/s_q=%b%b%b cnt=%0d expected 000 cnt=0",
                     out_valid, c_q, s_q, carry_cnt);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({out_valid, c_q, s_q} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_no_stale: got ov/c_q/s_q=%b%b%b expected 000", out_valid, c_q, s_q);
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0] seq [3];
        logic [2:0] want [3];
        seq  = '{2'b01, 2'b11, 2'b10};
        want = '{3'b101, 3'b011, 3'b101};  // {s_q, c_q, out_valid}
        for (int i = 0; i < 3; i++) begin
            cycle(seq[i][1], seq[i][0], 1'b1, 1'b0);
            n_checks++;
            if ({s_q, c_q, out_valid} !== want[i] || {s_q, c_q, out_valid} !== {exp_sq, exp_cq, exp_ov}) begin
                n_fail++;
                $display("FAIL b2b_%0d: got s_q/c_q/ov=%b%b%b expected %b", i, s_q, c_q, out_valid, want[i]);
            end
        end
    endtask

    task automatic test_random;
        logic ia, ib, iv, ir;
        for (int i = 0; i < 300; i++) begin
            ia = logic'($urandom_range(1));
            ib = logic'($urandom_range(1));
            iv = ($urandom_range(3) != 0);
            ir = ($urandom_range(39) == 0);
            cycle(ia, ib, iv, ir);
            n_checks++;
            if ({s_q, c_q, out_valid} !== {exp_sq, exp_cq, exp_ov} ||
                {s_q2, c_q2, out_valid2} !== {exp_sq, exp_cq, exp_ov} ||
                carry_cnt !== 16'(sat(n_carry, 16)) || carry_cnt2 !== 2'(sat(n_carry, 2)) ||
                {c, s} !== 2'(int'(ia) + int'(ib))) begin
                n_fail++;
                $display("FAIL random_%0d: got sq/cq/ov=%b%b%b cnt=%0d/%0d cs=%b%b expected %b%b%b cnt=%0d/%0d",
                         i, s_q, c_q, out_valid, carry_cnt, carry_cnt2, c, s,
                         exp_sq, exp_cq, exp_ov, sat(n_carry, 16), sat(n_carry, 2));
            end
        end
    endtask

    initial begin
        rst = 1'b1; a = 1'b0; b = 1'b0; in_valid = 1'b0;
        exp_sq = 1'b0; exp_cq = 1'b0; exp_ov = 1'b0; n_carry = 0;
        test_reset;
        test_comb(1'b0);
        test_comb(1'b1);
        test_registered;
        test_counter;
        test_saturation;
        test_reset_priority;
        test_back_to_back;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ha_1.md
HA_1 -- requirements
Module: ha_1

Interface
REQ-001 Parameter CNT_W, default 16: width of the carry-event counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 a  input  1  addend bit A.
REQ-005 b  input  1  addend bit B.
REQ-006 in_valid  input  1  qualifies a/b for the registered stage.
REQ-007 s  output  1  combinational sum.
REQ-008 c  output  1  combinational carry.
REQ-009 s_q  output  1  registered sum.
REQ-010 c_q  output  1  registered carry.
REQ-011 out_valid  output  1  s_q/c_q hold a valid result.
REQ-012 carry_cnt  output  CNT_W  saturating count of accepted operations with carry=1.

Function
REQ-013 s SHALL equal a XOR b, and c SHALL equal a AND b, purely combinationally with zero cycles of latency and independent of clk, rst and in_valid.
REQ-014 Truth table: 00->c0 s0; 01->c0 s1; 10->c0 s1; 11->c1 s0.
REQ-015 On a rising edge with in_valid=1, s_q/c_q SHALL load a XOR b / a AND b, giving one cycle of latency.
REQ-016 On a rising edge with in_valid=0, s_q/c_q SHALL hold their values.
REQ-017 out_valid SHALL be the registered copy of in_valid, asserted exactly one cycle after each accepted input and deasserted otherwise.
REQ-018 carry_cnt SHALL increment by 1 on each edge where in_valid=1 and a=b=1.
REQ-019 carry_cnt SHALL saturate at 2^CNT_W-1 and hold there; it SHALL never wrap.
REQ-020 There is no backpressure: every in_valid=1 cycle is accepted, and back-to-back operations are sustained at one per cycle.
REQ-021 The block SHALL produce no X on any output once rst has been applied for at least one edge, provided the inputs are known.

Reset
REQ-022 While rst=1 at a rising edge, the registers SHALL take: s_q=0, c_q=0, out_valid=0, carry_cnt=0.
REQ-023 rst SHALL take priority over in_valid; an operation presented in the same cycle as rst is discarded and not counted.
REQ-024 Asserting rst mid-stream SHALL clear out_valid on the next edge, with no stale result emitted afterwards.
REQ-025 The combinational outputs s and c SHALL be unaffected by rst.

Structure
REQ-026 No shared package is needed; CNT_W is a local parameter of the module.
REQ-027 The design SHALL be a single flat module with no sub-modules; the combinational sum/carry logic is reused to feed the register stage.

Verification
REQ-028 Exhaustive combinational check: apply a,b = 00, 01, 10, 11 with 1 time unit between steps -> c,s = 00, 01, 01, 10.
REQ-029 Registered path: in_valid=1 with a=1, b=1 at edge N -> at edge N+1, c_q=1, s_q=0, out_valid=1; then in_valid=0 -> out_valid=0 and s_q/c_q hold.
REQ-030 Counter: 5 accepted 11 operations interleaved with 3 accepted 01 operations -> carry_cnt=5.
REQ-031 Saturation with CNT_W=2: 6 accepted 11 operations -> carry_cnt=3 and stays at 3.
REQ-032 Reset priority: rst=1 together with in_valid=1, a=b=1 -> next cycle out_valid=0, c_q=0, carry_cnt=0, while c=1 combinationally.
REQ-033 Back-to-back sequence 01, 11, 10 on consecutive cycles with in_valid=1 -> s_q/c_q sequence 1/0, 0/1, 1/0 with out_valid held at 1.
